// File: rtl/wasm_core_pkg.sv
// Shared constants for the wasm_core stack machine: value types, trap codes, opcodes, FSM states.
package wasm_core_pkg;

    localparam logic [1:0] TyI32 = 2'd0;
    localparam logic [1:0] TyI64 = 2'd1;
    localparam logic [1:0] TyF32 = 2'd2;
    localparam logic [1:0] TyF64 = 2'd3;

    localparam logic [3:0] TrapNone        = 4'd0;
    localparam logic [3:0] TrapEnded       = 4'd1;
    localparam logic [3:0] TrapUnreachable = 4'd2;
    localparam logic [3:0] TrapBadOpcode   = 4'd3;
    localparam logic [3:0] TrapUnderflow   = 4'd4;
    localparam logic [3:0] TrapNoFpu       = 4'd5;
    localparam logic [3:0] TrapMemError    = 4'd6;
    localparam logic [3:0] TrapOverflow    = 4'd7;
    localparam logic [3:0] TrapNo64b       = 4'd8;

    localparam logic [7:0] OpUnreachable  = 8'h00;
    localparam logic [7:0] OpNop          = 8'h01;
    localparam logic [7:0] OpEnd          = 8'h0B;
    localparam logic [7:0] OpDrop         = 8'h1A;
    localparam logic [7:0] OpI32Const     = 8'h41;
    localparam logic [7:0] OpI64Const     = 8'h42;
    localparam logic [7:0] OpF32Const     = 8'h43;
    localparam logic [7:0] OpF64Const     = 8'h44;
    localparam logic [7:0] OpI32ReintF32  = 8'hBC;
    localparam logic [7:0] OpI64ReintF64  = 8'hBD;
    localparam logic [7:0] OpF32ReintI32  = 8'hBE;
    localparam logic [7:0] OpF64ReintI64  = 8'hBF;

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;
    typedef enum logic [1:0] {StackNone, StackPush, StackPop, StackRelabel} stack_op_e;

endpackage

// File: rtl/wasm_leb128_decode.sv
// Signed LEB128 decoder over a 10-byte window (first byte in [79:72]); stops at max_bytes_i.
module wasm_leb128_decode (
    input  logic [79:0] bytes_i,
    input  logic [3:0]  max_bytes_i,
    output logic [63:0] value_o,
    output logic [3:0]  len_o,
    output logic        malformed_o
);
    logic [69:0] acc;
    logic        done;
    logic        unused_acc_hi;

    always_comb begin
        acc         = '0;
        done        = 1'b0;
        len_o       = '0;
        malformed_o = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!done && i < int'(max_bytes_i)) begin
                acc[7*i +: 7] = bytes_i[78-8*i -: 7];
                if (!bytes_i[79-8*i]) begin
                    done        = 1'b1;
                    malformed_o = 1'b0;
                    len_o       = 4'(i + 1);
                    // Bit 6 of the final byte is the sign; extend it above the decoded bits.
                    if (bytes_i[78-8*i]) begin
                        acc = acc | ({70{1'b1}} << (7 * (i + 1)));
                    end
                end
            end
        end
        value_o = acc[63:0];
    end

    assign unused_acc_hi = ^acc[69:64];

endmodule

// File: rtl/wasm_core.sv
// Minimal WebAssembly stack-machine core: FETCH -> DECODE -> EXEC per instruction.
// Define WASM_CORE_STACK_CHECK_EN to trap on stack underflow/overflow instead of tolerating it.
module wasm_core
    import wasm_core_pkg::*;
#(
    parameter int unsigned HAS_FPU     = 1,
    parameter int unsigned USE_64B     = 1,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [63:0]        result,
    output logic [1:0]         result_type,
    output logic               result_empty,
    output logic [3:0]         trap,
    output logic [MEM_DEPTH:0] mem_addr,
    output logic [3:0]         mem_extra,
    input  logic [127:0]       mem_data,
    input  logic               mem_error
);
    localparam int unsigned PcW  = MEM_DEPTH + 1;
    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);

    state_e              state_q, state_d;
    logic [PcW-1:0]      pc_q, pc_d;
    logic [3:0]          trap_q, trap_d;
    logic [SpW-1:0]      sp_q, sp_d;
    logic [63:0]         stk_val_q [STACK_DEPTH];
    logic [63:0]         stk_val_d [STACK_DEPTH];
    logic [1:0]          stk_typ_q [STACK_DEPTH];
    logic [1:0]          stk_typ_d [STACK_DEPTH];
    stack_op_e           op_q, op_d;
    logic [63:0]         imm_q, imm_d;
    logic [1:0]          imm_type_q, imm_type_d;
    logic [3:0]          len_q, len_d;

    logic                stk_empty, stk_full;
    logic [IdxW-1:0]     top_idx, wr_idx;
    logic [63:0]         top_val;
    logic [1:0]          top_type;

    logic [7:0]          opcode;
    logic [3:0]          leb_max, leb_len;
    logic [63:0]         leb_value, le_bytes;
    logic                leb_malformed;
    stack_op_e           dec_op;
    logic [63:0]         dec_val;
    logic [1:0]          dec_type, dec_need;
    logic [3:0]          dec_len, dec_trap;
    logic                is_float, is_64;
    logic                unused_win;

    assign opcode     = mem_data[127:120];
    assign leb_max    = (opcode == OpI64Const) ? 4'd10 : 4'd5;
    assign unused_win = ^mem_data[39:0];

    wasm_leb128_decode u_leb (
        .bytes_i     (mem_data[119:40]),
        .max_bytes_i (leb_max),
        .value_o     (leb_value),
        .len_o       (leb_len),
        .malformed_o (leb_malformed)
    );

    // An empty stack reads as value 0 of type i32.
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SpW'(STACK_DEPTH));
    assign top_idx   = IdxW'(sp_q - SpW'(1));
    assign top_val   = stk_empty ? '0 : stk_val_q[top_idx];
    assign top_type  = stk_empty ? TyI32 : stk_typ_q[top_idx];

    always_comb begin
        dec_op   = StackNone;
        dec_val  = '0;
        dec_type = TyI32;
        dec_need = TyI32;
        dec_len  = 4'd1;
        dec_trap = TrapNone;
        is_float = 1'b0;
        is_64    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            le_bytes[8*k +: 8] = mem_data[119-8*k -: 8];
        end
        case (opcode)
            OpUnreachable: dec_trap = TrapUnreachable;
            OpNop:         ;
            OpEnd:         dec_trap = TrapEnded;
            OpDrop:        dec_op = StackPop;
            OpI32Const: begin
                dec_op  = StackPush;
                dec_val = {32'd0, leb_value[31:0]};
                dec_len = leb_len + 4'd1;
                if (leb_malformed) dec_trap = TrapBadOpcode;
            end
            OpI64Const: begin
                is_64    = 1'b1;
                dec_op   = StackPush;
                dec_val  = leb_value;
                dec_type = TyI64;
                dec_len  = leb_len + 4'd1;
                if (leb_malformed) dec_trap = TrapBadOpcode;
            end
            OpF32Const: begin
                is_float = 1'b1;
                dec_op   = StackPush;
                dec_val  = {32'd0, le_bytes[31:0]};
                dec_type = TyF32;
                dec_len  = 4'd5;
            end
            OpF64Const: begin
                is_float = 1'b1;
                is_64    = 1'b1;
                dec_op   = StackPush;
                dec_val  = le_bytes;
                dec_type = TyF64;
                dec_len  = 4'd9;
            end
            OpI32ReintF32: begin
                is_float = 1'b1;
                dec_op   = StackRelabel;
                dec_type = TyI32;
                dec_need = TyF32;
            end
            OpI64ReintF64: begin
                is_float = 1'b1;
                is_64    = 1'b1;
                dec_op   = StackRelabel;
                dec_type = TyI64;
                dec_need = TyF64;
            end
            OpF32ReintI32: begin
                is_float = 1'b1;
                dec_op   = StackRelabel;
                dec_type = TyF32;
                dec_need = TyI32;
            end
            OpF64ReintI64: begin
                is_float = 1'b1;
                is_64    = 1'b1;
                dec_op   = StackRelabel;
                dec_type = TyF64;
                dec_need = TyI64;
            end
            default: dec_trap = TrapBadOpcode;
        endcase

        // Later assignments override earlier ones, giving the fault priority order.
        if (dec_trap == TrapNone && dec_op == StackRelabel && top_type != dec_need) begin
            dec_trap = TrapBadOpcode;
        end
`ifdef WASM_CORE_STACK_CHECK_EN
        if (dec_trap == TrapNone) begin
            if ((dec_op == StackPop || dec_op == StackRelabel) && stk_empty) begin
                dec_trap = TrapUnderflow;
            end else if (dec_op == StackPush && stk_full) begin
                dec_trap = TrapOverflow;
            end
        end
`endif
        if (is_64 && USE_64B == 0) dec_trap = TrapNo64b;
        if (is_float && HAS_FPU == 0) dec_trap = TrapNoFpu;
        if (mem_error) dec_trap = TrapMemError;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        trap_d     = trap_q;
        sp_d       = sp_q;
        stk_val_d  = stk_val_q;
        stk_typ_d  = stk_typ_q;
        op_d       = op_q;
        imm_d      = imm_q;
        imm_type_d = imm_type_q;
        len_d      = len_q;
        // Without stack checking a push onto a full stack overwrites the top entry.
        wr_idx     = stk_full ? top_idx : IdxW'(sp_q);
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                op_d       = dec_op;
                imm_d      = dec_val;
                imm_type_d = dec_type;
                len_d      = dec_len;
                if (dec_trap != TrapNone) begin
                    trap_d  = dec_trap;
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                pc_d    = pc_q + PcW'(len_q);
                state_d = StFetch;
                case (op_q)
                    StackPush: begin
                        stk_val_d[wr_idx] = imm_q;
                        stk_typ_d[wr_idx] = imm_type_q;
                        if (!stk_full) sp_d = sp_q + SpW'(1);
                    end
                    StackPop: begin
                        if (!stk_empty) sp_d = sp_q - SpW'(1);
                    end
                    StackRelabel: begin
                        if (stk_empty) begin
                            stk_val_d[0] = '0;
                            stk_typ_d[0] = imm_type_q;
                            sp_d         = SpW'(1);
                        end else begin
                            stk_typ_d[top_idx] = imm_type_q;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            trap_q     <= TrapNone;
            sp_q       <= '0;
            op_q       <= StackNone;
            imm_q      <= '0;
            imm_type_q <= TyI32;
            len_q      <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_val_q[i] <= '0;
                stk_typ_q[i] <= TyI32;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            trap_q     <= trap_d;
            sp_q       <= sp_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            imm_type_q <= imm_type_d;
            len_q      <= len_d;
            stk_val_q  <= stk_val_d;
            stk_typ_q  <= stk_typ_d;
        end
    end

    assign result       = top_val;
    assign result_type  = top_type;
    assign result_empty = stk_empty;
    assign trap         = trap_q;
    assign mem_addr     = pc_q;
    assign mem_extra    = 4'd15;

endmodule

// File: tb/tb_wasm_core.sv
// Self-checking bench for wasm_core: a shared ROM model feeds three builds (full, no FPU, no 64-bit).
module tb_wasm_core;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] rom [64];

    logic [63:0]  res_a, res_b, res_c;
    logic [1:0]   typ_a, typ_b, typ_c;
    logic         emp_a, emp_b, emp_c;
    logic [3:0]   trap_a, trap_b, trap_c;
    logic [16:0]  addr_a, addr_b, addr_c;
    logic [3:0]   extra_a, extra_b, extra_c;
    logic [127:0] data_a, data_b, data_c;
    logic         err_a, err_b, err_c;
    logic [70:0]  got_a, got_b, got_c;

    assign got_a = {res_a, typ_a, emp_a, trap_a};
    assign got_b = {res_b, typ_b, emp_b, trap_b};
    assign got_c = {res_c, typ_c, emp_c, trap_c};

    wasm_core #(.HAS_FPU(1), .USE_64B(1), .MEM_DEPTH(16), .STACK_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .result(res_a), .result_type(typ_a), .result_empty(emp_a),
        .trap(trap_a), .mem_addr(addr_a), .mem_extra(extra_a), .mem_data(data_a),
        .mem_error(err_a)
    );
    wasm_core #(.HAS_FPU(0), .USE_64B(1), .MEM_DEPTH(16), .STACK_DEPTH(8)) dut_b (
        .clk(clk), .reset(reset), .result(res_b), .result_type(typ_b), .result_empty(emp_b),
        .trap(trap_b), .mem_addr(addr_b), .mem_extra(extra_b), .mem_data(data_b),
        .mem_error(err_b)
    );
    wasm_core #(.HAS_FPU(1), .USE_64B(0), .MEM_DEPTH(16), .STACK_DEPTH(8)) dut_c (
        .clk(clk), .reset(reset), .result(res_c), .result_type(typ_c), .result_empty(emp_c),
        .trap(trap_c), .mem_addr(addr_c), .mem_extra(extra_c), .mem_data(data_c),
        .mem_error(err_c)
    );

    function automatic logic [127:0] window(input logic [16:0] a);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) begin
            w[127-8*k -: 8] = (int'(a) + k < 64) ? rom[int'(a) + k] : 8'h00;
        end
        return w;
    endfunction

    // Synchronous ROM: one-cycle read latency, error when the 16-byte window leaves the ROM.
    always @(posedge clk) begin
        data_a <= window(addr_a);
        data_b <= window(addr_b);
        data_c <= window(addr_c);
        err_a  <= int'(addr_a) > 48;
        err_b  <= int'(addr_b) > 48;
        err_c  <= int'(addr_c) > 48;
    end

    int tests = 0;
    int fails = 0;
    logic [70:0] sb[$];

    function automatic logic [70:0] pack(input logic [63:0] r, input logic [1:0] t,
                                         input logic e, input logic [3:0] tr);
        return {r, t, e, tr};
    endfunction

    task automatic load_prog(input logic [255:0] p, input int n);
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < n; i++) rom[i] = p[8*(n-1-i) +: 8];
    endtask

    task automatic start_prog();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 2000 && trap_a == 4'd0; i++) cycles(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests++;
        if ({got_a, addr_a, extra_a} !== {pack(64'd0, 2'd0, 1'b1, 4'd0), 17'd0, 4'd15}) begin
            $display("FAIL reset_a: got {res,type,empty,trap,addr,extra}=%h, expected %h",
                     {got_a, addr_a, extra_a}, {pack(64'd0, 2'd0, 1'b1, 4'd0), 17'd0, 4'd15});
            fails++;
        end
        tests++;
        if ({got_b, got_c} !== {pack(64'd0, 2'd0, 1'b1, 4'd0), pack(64'd0, 2'd0, 1'b1, 4'd0)}) begin
            $display("FAIL reset_bc: got %h, expected all-reset state", {got_b, got_c});
            fails++;
        end
    endtask

    task automatic test_f32_reinterpret();
        logic [70:0] e;
        load_prog(256'h43000000C0BC0B, 7);
        sb.push_back(pack(64'hC000_0000, 2'd0, 1'b0, 4'd1));
        start_prog();
        cycles(7);
        tests++;
        if (trap_a !== 4'd0) begin
            $display("FAIL f32_latency: trap after 7 cycles=%0d, expected 0", trap_a);
            fails++;
        end
        cycles(2);
        e = sb.pop_front();
        tests++;
        if (got_a !== e) begin
            $display("FAIL f32_reinterpret: got {res,type,empty,trap}=%h, expected %h", got_a, e);
            fails++;
        end
    endtask

    task automatic test_feature_gates();
        logic [70:0] e;
        load_prog(256'h43000000C0BC0B, 7);
        sb.push_back(pack(64'd0, 2'd0, 1'b1, 4'd5));
        start_prog();
        cycles(6);
        e = sb.pop_front();
        tests++;
        if (got_b !== e) begin
            $display("FAIL no_fpu: got {res,type,empty,trap}=%h, expected %h", got_b, e);
            fails++;
        end
        load_prog(256'h4280010B, 4);
        sb.push_back(pack(64'd0, 2'd0, 1'b1, 4'd8));
        sb.push_back(pack(64'd128, 2'd1, 1'b0, 4'd1));
        start_prog();
        cycles(6);
        e = sb.pop_front();
        tests++;
        if (got_c !== e) begin
            $display("FAIL no_64b: got {res,type,empty,trap}=%h, expected %h", got_c, e);
            fails++;
        end
        cycles(6);
        e = sb.pop_front();
        tests++;
        if (got_b !== e) begin
            $display("FAIL no_fpu_i64: got {res,type,empty,trap}=%h, expected %h", got_b, e);
            fails++;
        end
    endtask

    task automatic test_leb128();
        logic [255:0] progs [5];
        int           lens [5];
        logic [70:0]  exps [5];
        logic [70:0]  e;
        progs = '{256'h417F0B, 256'h4280010B, 256'h42807F0B, 256'h41FFFFFFFF0F0B,
                  256'h42FFFFFFFFFFFFFFFFFF7F0B};
        lens  = '{3, 4, 4, 7, 12};
        exps  = '{pack(64'hFFFF_FFFF, 2'd0, 1'b0, 4'd1),
                  pack(64'd128, 2'd1, 1'b0, 4'd1),
                  pack(64'hFFFF_FFFF_FFFF_FF80, 2'd1, 1'b0, 4'd1),
                  pack(64'hFFFF_FFFF, 2'd0, 1'b0, 4'd1),
                  pack(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 4'd1)};
        for (int i = 0; i < 5; i++) begin
            load_prog(progs[i], lens[i]);
            sb.push_back(exps[i]);
            start_prog();
            wait_halt();
            e = sb.pop_front();
            tests++;
            if (got_a !== e) begin
                $display("FAIL leb128[%0d]: got {res,type,empty,trap}=%h, expected %h", i, got_a, e);
                fails++;
            end
        end
    endtask

    task automatic test_relabel();
        logic [255:0] progs [4];
        int           lens [4];
        logic [70:0]  exps [4];
        logic [70:0]  e;
        progs = '{256'h4105BEBC0B, 256'h4105BC, 256'h440102030405060708BD0B, 256'h427FBF0B};
        lens  = '{5, 3, 11, 4};
        exps  = '{pack(64'd5, 2'd0, 1'b0, 4'd1),
                  pack(64'd5, 2'd0, 1'b0, 4'd3),
                  pack(64'h0807_0605_0403_0201, 2'd1, 1'b0, 4'd1),
                  pack(64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b0, 4'd1)};
        for (int i = 0; i < 4; i++) begin
            load_prog(progs[i], lens[i]);
            sb.push_back(exps[i]);
            start_prog();
            wait_halt();
            e = sb.pop_front();
            tests++;
            if (got_a !== e) begin
                $display("FAIL relabel[%0d]: got {res,type,empty,trap}=%h, expected %h", i, got_a, e);
                fails++;
            end
        end
    endtask

    task automatic test_traps();
        logic [255:0] progs [3];
        int           lens [3];
        logic [70:0]  exps [3];
        logic [70:0]  e;
        progs = '{256'h00, 256'hFF, 256'h418080808080};
        lens  = '{1, 1, 6};
        exps  = '{pack(64'd0, 2'd0, 1'b1, 4'd2),
                  pack(64'd0, 2'd0, 1'b1, 4'd3),
                  pack(64'd0, 2'd0, 1'b1, 4'd3)};
        for (int i = 0; i < 3; i++) begin
            load_prog(progs[i], lens[i]);
            sb.push_back(exps[i]);
            start_prog();
            wait_halt();
            e = sb.pop_front();
            tests++;
            if (got_a !== e) begin
                $display("FAIL traps[%0d]: got {res,type,empty,trap}=%h, expected %h", i, got_a, e);
                fails++;
            end
        end
    endtask

    task automatic test_stack_check();
        logic [255:0] p;
        logic [70:0]  e;
        p = '0;
        for (int k = 1; k <= 9; k++) p = (p << 16) | {240'd0, 8'h41, 8'(k)};
        p = (p << 8) | 256'h0B;
`ifdef WASM_CORE_STACK_CHECK_EN
        sb.push_back(pack(64'd0, 2'd0, 1'b1, 4'd4));
        sb.push_back(pack(64'd8, 2'd0, 1'b0, 4'd7));
`else
        sb.push_back(pack(64'd0, 2'd0, 1'b1, 4'd1));
        sb.push_back(pack(64'd9, 2'd0, 1'b0, 4'd1));
`endif
        load_prog(256'h1A0B, 2);
        start_prog();
        wait_halt();
        e = sb.pop_front();
        tests++;
        if (got_a !== e) begin
            $display("FAIL drop_empty: got {res,type,empty,trap}=%h, expected %h", got_a, e);
            fails++;
        end
        load_prog(p, 19);
        start_prog();
        wait_halt();
        e = sb.pop_front();
        tests++;
        if (got_a !== e) begin
            $display("FAIL push_full: got {res,type,empty,trap}=%h, expected %h", got_a, e);
            fails++;
        end
    endtask

    task automatic test_mem_error();
        logic [70:0] e;
        for (int i = 0; i < 64; i++) rom[i] = (i < 49) ? 8'h01 : 8'h0B;
        sb.push_back(pack(64'd0, 2'd0, 1'b1, 4'd6));
        start_prog();
        wait_halt();
        e = sb.pop_front();
        tests++;
        if ({got_a, addr_a} !== {e, 17'd49}) begin
            $display("FAIL mem_error: got {state,addr}=%h, expected %h", {got_a, addr_a},
                     {e, 17'd49});
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        logic [70:0] e;
        load_prog(256'h43000000C0BC0B, 7);
        start_prog();
        cycles(4);
        reset = 1'b0;
        #1;
        tests++;
        if ({got_a, addr_a} !== {pack(64'd0, 2'd0, 1'b1, 4'd0), 17'd0}) begin
            $display("FAIL reset_mid_exec: got {state,addr}=%h, expected reset state",
                     {got_a, addr_a});
            fails++;
        end
        start_prog();
        cycles(1);
        reset = 1'b0;
        #1;
        tests++;
        if ({got_a, addr_a} !== {pack(64'd0, 2'd0, 1'b1, 4'd0), 17'd0}) begin
            $display("FAIL reset_mid_decode: got {state,addr}=%h, expected reset state",
                     {got_a, addr_a});
            fails++;
        end
        sb.push_back(pack(64'hC000_0000, 2'd0, 1'b0, 4'd1));
        start_prog();
        cycles(9);
        e = sb.pop_front();
        tests++;
        if (got_a !== e) begin
            $display("FAIL reset_rerun: got {res,type,empty,trap}=%h, expected %h", got_a, e);
            fails++;
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_f32_reinterpret();
        test_feature_gates();
        test_leb128();
        test_relabel();
        test_traps();
        test_stack_check();
        test_mem_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
